imul_dot_requester: RTL and testbench
=====================================

Name: imul_dot_requester

Overview:
- Initiator-side companion to the iterative integer multiplier.
- Accepts a stream of 32-bit operand pairs terminated by a last flag and issues each pair as a val/rdy multiply request.
- Accumulates the 32-bit product responses and emits one dot-product result per stream, with the pair count.
- Keeps up to MAX_OUTSTANDING requests in flight using a credit counter.

Parameters:
MAX_OUTSTANDING, 2, max requests issued without a response (1..15)
CNT_NBITS, 16, width of the pair counter reported with each result

Ports:
clk  in  1  clock
reset  in  1  reset (one clock; reset is asynchronous and active-low)
in_val  in  1  operand pair valid
in_rdy  out  1  operand pair ready
in_msg  in  64  {a[63:32], b[31:0]}
in_last  in  1  final pair of the stream; qualified by in_val
mul_req_val  out  1  multiply request valid
mul_req_rdy  in  1  multiplier ready
mul_req_msg  out  64  {a, b}, passed through from in_msg
mul_resp_val  in  1  product valid
mul_resp_rdy  out  1  product ready
mul_resp_msg  in  32  product, low 32 bits
out_val  out  1  result valid
out_rdy  in  1  result consumer ready
out_msg  out  32  accumulated sum, mod 2^32
out_count  out  CNT_NBITS  pairs in the stream, mod 2^CNT_NBITS

Behaviour:
- Reset asserted (reset==0):
  - state=ISSUE; acc=0, count=0, outstanding=0.
  - in_rdy, mul_req_val, mul_resp_rdy and out_val are forced to 0 while reset is held.
- credit_ok = (outstanding < MAX_OUTSTANDING).
- ISSUE:
  - Pass-through, zero added latency. mul_req_val = in_val & credit_ok; in_rdy = mul_req_rdy & credit_ok; mul_req_msg = in_msg.
  - Fire = in_val & in_rdy. On fire: count++, outstanding++.
  - Fire with in_last: next state DRAIN.
- DRAIN: in_rdy=0, mul_req_val=0. Go to DONE when outstanding==0 and no response fires this cycle, or when outstanding==1 and a response fires this cycle.
- mul_resp_rdy:
  - 1 in ISSUE and DRAIN, 0 in DONE.
  - On response fire: acc += mul_resp_msg (mod 2^32); outstanding--.
- Issue and response in the same cycle: outstanding is unchanged; count and acc both update.
- DONE:
  - out_val=1, out_msg=acc, out_count=count. Values are registered and stable while out_val=1 and out_rdy=0.
  - On out fire: acc=0, count=0, next state ISSUE. in_rdy is 0 in DONE, so a new stream starts the cycle after the out fire at the earliest.
- Responses arrive in request order; summation is order-independent, so no tags are kept.
- Unexpected response (response fire with outstanding==0, only possible in ISSUE): outstanding stays 0 and never underflows; acc still adds the product.
- Stream of one pair (first fire carries in_last) is legal: ISSUE→DRAIN→DONE.
- Reset mid-operation: all state is cleared immediately. Responses to requests issued before reset are treated as unexpected.
- Overflow: acc and count wrap silently.

Optional Feature:
IMUL_DOT_ERR_CHECK_EN
- Defined: adds output port err (1 bit).
  - err is sticky and set on an unexpected response, or on in_val=1 while in DONE.
  - err is cleared only by reset; reset value 0.
  - The unexpected product is discarded rather than accumulated.
- Undefined: no err port, no checking logic; behaviour as in Behaviour above.

Decomposition:
- Package imul_dot_pkg:
  - state enum {STATE_ISSUE, STATE_DRAIN, STATE_DONE}, 2 bits;
  - operand/product widths (32, 64);
  - message field offsets for a and b.
- Sub-module imul_dot_credit_ctr: up/down counter with asynchronous active-low reset, simultaneous inc/dec (net zero), saturation at 0, and a credit_ok output.
- FSM, accumulator and pair counter live in the top module.

Test Plan:
- Pairs (2,3),(4,5 last); multiplier model with 3-cycle latency, out_rdy=1 → out_msg=26, out_count=2, out_val for one cycle.
- Single pair (0xFFFFFFFF,2 last) → out_msg=0xFFFFFFFE, out_count=1; the next stream (1,1 last) → out_msg=1, proving acc/count clear.
- Wrap: (0x80000000,1),(0x80000000,1 last) → out_msg=0, out_count=2.
- Credit limit, MAX_OUTSTANDING=2: model withholds responses, 4 pairs offered → exactly 2 request fires, then in_rdy=0 until the first response; final sum correct. Also mul_req_rdy=0 → in_rdy=0.
- Backpressure and reset: out_rdy=0 for 5 cycles in DONE → out_msg/out_count held, in_rdy=0. Reset pulsed in DRAIN with 1 outstanding → all outputs 0, outstanding=0. Late response after reset → err=1 with macro defined; outstanding stays 0 either way.

Source files
------------

// File: rtl/imul_dot_pkg.sv
// rtl/imul_dot_pkg.sv - shared widths, message field offsets and FSM states for the dot-product requester
package imul_dot_pkg;

    localparam int OPND_W = 32;
    localparam int MSG_W  = 64;
    localparam int PROD_W = 32;

    // Operand pair message layout: {a, b}
    localparam int A_LSB = 32;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        STATE_ISSUE = 2'd0,
        STATE_DRAIN = 2'd1,
        STATE_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/imul_dot_credit_ctr.sv
// rtl/imul_dot_credit_ctr.sv - outstanding-request counter with credit check and floor at zero
module imul_dot_credit_ctr #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CW              = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          credit_ok_o
);

    logic [CW-1:0] count_q, count_d;

    // Simultaneous inc/dec cancels; a lone dec at zero is a stray response and is ignored
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            count_d = count_q + CW'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign credit_ok_o = (count_q < CW'(MAX_OUTSTANDING));

endmodule

// File: rtl/imul_dot_requester.sv
// rtl/imul_dot_requester.sv - streams operand pairs to a multiplier and sums products per stream; IMUL_DOT_ERR_CHECK_EN adds sticky err
module imul_dot_requester
    import imul_dot_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_NBITS       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [MSG_W-1:0]     in_msg,
    input  logic                 in_last,
    output logic                 mul_req_val,
    input  logic                 mul_req_rdy,
    output logic [MSG_W-1:0]     mul_req_msg,
    input  logic                 mul_resp_val,
    output logic                 mul_resp_rdy,
    input  logic [PROD_W-1:0]    mul_resp_msg,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [PROD_W-1:0]    out_msg,
    output logic [CNT_NBITS-1:0] out_count
`ifdef IMUL_DOT_ERR_CHECK_EN
    ,
    output logic                 err
`endif
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    state_e                 state_q, state_d;
    logic [PROD_W-1:0]      acc_q, acc_d;
    logic [CNT_NBITS-1:0]   count_q, count_d;
    logic [CW-1:0]          outstanding;
    logic                   credit_ok;
    logic                   in_fire, resp_fire, out_fire;
    logic                   resp_unexpected, resp_accept;

    imul_dot_credit_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CW              (CW)
    ) u_credit (
        .clk_i       (clk),
        .rst_ni      (reset),
        .inc_i       (in_fire),
        .dec_i       (resp_fire),
        .count_o     (outstanding),
        .credit_ok_o (credit_ok)
    );

    // Handshake outputs per state; all valid/ready outputs held low while reset is asserted
    always_comb begin
        in_rdy       = 1'b0;
        mul_req_val  = 1'b0;
        mul_resp_rdy = 1'b0;
        out_val      = 1'b0;
        if (reset) begin
            case (state_q)
                STATE_ISSUE: begin
                    in_rdy       = mul_req_rdy & credit_ok;
                    mul_req_val  = in_val & credit_ok;
                    mul_resp_rdy = 1'b1;
                end
                STATE_DRAIN: mul_resp_rdy = 1'b1;
                STATE_DONE:  out_val      = 1'b1;
                default: ;
            endcase
        end
    end

    assign mul_req_msg     = in_msg;
    assign in_fire         = in_val & in_rdy;
    assign resp_fire       = mul_resp_val & mul_resp_rdy;
    assign out_fire        = out_val & out_rdy;
    assign resp_unexpected = resp_fire & (outstanding == '0);

`ifdef IMUL_DOT_ERR_CHECK_EN
    assign resp_accept = resp_fire & ~resp_unexpected;
`else
    assign resp_accept = resp_fire;
`endif

    assign out_msg   = acc_q;
    assign out_count = count_q;

    // Next-state, accumulator and pair-count update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        if (resp_accept) begin
            acc_d = acc_q + mul_resp_msg;
        end
        if (in_fire) begin
            count_d = count_q + CNT_NBITS'(1);
        end
        case (state_q)
            STATE_ISSUE: begin
                if (in_fire && in_last) begin
                    state_d = STATE_DRAIN;
                end
            end
            STATE_DRAIN: begin
                if (((outstanding == CW'(0)) && !resp_fire) ||
                    ((outstanding == CW'(1)) && resp_fire)) begin
                    state_d = STATE_DONE;
                end
            end
            STATE_DONE: begin
                if (out_fire) begin
                    state_d = STATE_ISSUE;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            default: state_d = STATE_ISSUE;
        endcase
    end

    // State, accumulator and pair-count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STATE_ISSUE;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

`ifdef IMUL_DOT_ERR_CHECK_EN
    logic err_q;

    // Sticky protocol error: stray response, or a new pair offered while the result is pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (resp_unexpected || ((state_q == STATE_DONE) && in_val)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_imul_dot_requester.sv
// tb/tb_imul_dot_requester.sv - randomized self-checking bench with in-order multiplier model and sum reference
module tb_imul_dot_requester;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_val = 1'b0;
    logic        in_last = 1'b0;
    logic [63:0] in_msg = '0;
    logic        mul_req_rdy = 1'b1;
    logic        mul_resp_val = 1'b0;
    logic [31:0] mul_resp_msg = '0;
    logic        out_rdy = 1'b1;
    logic        in_rdy, mul_req_val, mul_resp_rdy, out_val;
    logic [63:0] mul_req_msg;
    logic [31:0] out_msg;
    logic [15:0] out_count;
`ifdef IMUL_DOT_ERR_CHECK_EN
    logic        err;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] va [16];
    logic [31:0] vb [16];

    // multiplier model controls and state
    bit          hold_resp = 1'b0;
    bit          req_rdy_en = 1'b1;
    bit          rand_rdy = 1'b0;
    int          lat_min = 3;
    int          lat_max = 3;
    int          cyc = 0;
    logic [31:0] pq [$];
    int          tq [$];

    imul_dot_requester #(.MAX_OUTSTANDING(2), .CNT_NBITS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_val       (in_val),
        .in_rdy       (in_rdy),
        .in_msg       (in_msg),
        .in_last      (in_last),
        .mul_req_val  (mul_req_val),
        .mul_req_rdy  (mul_req_rdy),
        .mul_req_msg  (mul_req_msg),
        .mul_resp_val (mul_resp_val),
        .mul_resp_rdy (mul_resp_rdy),
        .mul_resp_msg (mul_resp_msg),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
        .out_msg      (out_msg),
        .out_count    (out_count)
`ifdef IMUL_DOT_ERR_CHECK_EN
        ,
        .err          (err)
`endif
    );

    initial forever #5 clk = ~clk;

    // In-order multiplier: product of each accepted request is returned after a latency
    initial begin
        logic        rq, rs;
        logic [63:0] rmsg;
        forever begin
            @(negedge clk);
            rq   = mul_req_val && mul_req_rdy;
            rs   = mul_resp_val && mul_resp_rdy;
            rmsg = mul_req_msg;
            @(posedge clk);
            #1;
            cyc++;
            if (rs) begin
                void'(pq.pop_front());
                void'(tq.pop_front());
            end
            if (rq) begin
                logic [31:0] pa, pb, pp;
                pa = rmsg[63:32];
                pb = rmsg[31:0];
                pp = pa * pb;
                pq.push_back(pp);
                tq.push_back(cyc + int'($urandom_range(lat_max, lat_min)) - 1);
            end
            mul_req_rdy = rand_rdy ? ($urandom_range(3, 0) != 0) : req_rdy_en;
            if (!hold_resp && (pq.size() > 0) && (cyc >= tq[0])) begin
                mul_resp_val = 1'b1;
                mul_resp_msg = pq[0];
            end else begin
                mul_resp_val = 1'b0;
                mul_resp_msg = '0;
            end
        end
    end

    function automatic logic [31:0] ref_sum(input int n);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < n; i++) s = s + va[i] * vb[i];
        return s;
    endfunction

    task automatic offer(input int n, input int max_cyc, inout int idx);
        for (int c = 0; c < max_cyc && idx < n; c++) begin
            in_val  = 1'b1;
            in_msg  = {va[idx], vb[idx]};
            in_last = (idx == n - 1);
            @(negedge clk);
            if (in_rdy) idx++;
            @(posedge clk);
            #1;
        end
        in_val  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_out(input bit consume, output logic [31:0] msg, output logic [15:0] cnt,
                            output bit to, output bit val_after);
        out_rdy   = consume;
        to        = 1'b1;
        val_after = 1'b1;
        msg       = '0;
        cnt       = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (out_val) begin
                msg = out_msg;
                cnt = out_count;
                to  = 1'b0;
                @(posedge clk);
                #1;
                if (consume) begin
                    @(negedge clk);
                    val_after = out_val;
                    @(posedge clk);
                    #1;
                end
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        in_val = 1'b1;
        in_msg = 64'h0000_0002_0000_0003;
        @(negedge clk);
        checks++;
        if ({in_rdy, mul_req_val, mul_resp_rdy, out_val} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000", {in_rdy, mul_req_val, mul_resp_rdy, out_val});
        end
        @(posedge clk);
        #1;
        reset  = 1'b1;
        in_val = 1'b0;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
        checks++;
        if (mul_resp_rdy !== 1'b1) begin failures++; $display("FAIL reset_resp_rdy got=%b exp=1", mul_resp_rdy); end
        checks++;
        if ({mul_req_val, out_val} !== 2'b00) begin failures++; $display("FAIL reset_val got=%b exp=00", {mul_req_val, out_val}); end
        checks++;
        if ({out_msg, out_count} !== 48'h0) begin failures++; $display("FAIL reset_acc got=%h exp=0", {out_msg, out_count}); end
`ifdef IMUL_DOT_ERR_CHECK_EN
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int idx; logic [31:0] m; logic [15:0] c; bit to, va_after;
        va[0] = 2; vb[0] = 3; va[1] = 4; vb[1] = 5;
        idx = 0;
        offer(2, 200, idx);
        wait_out(1'b1, m, c, to, va_after);
        checks++;
        if (idx != 2 || to) begin failures++; $display("FAIL basic_progress got=%0d/%0b exp=2/0", idx, to); end
        checks++;
        if (m !== 32'd26) begin failures++; $display("FAIL basic_sum got=%0d exp=26", m); end
        checks++;
        if (c !== 16'd2) begin failures++; $display("FAIL basic_count got=%0d exp=2", c); end
        checks++;
        if (va_after !== 1'b0) begin failures++; $display("FAIL basic_out_val_one_cycle got=%b exp=0", va_after); end
    endtask

    task automatic test_single_then_next;
        int idx; logic [31:0] m; logic [15:0] c; bit to, v;
        va[0] = 32'hFFFF_FFFF; vb[0] = 2;
        idx = 0;
        offer(1, 200, idx);
        wait_out(1'b1, m, c, to, v);
        checks++;
        if (to || m !== 32'hFFFF_FFFE) begin failures++; $display("FAIL single_sum got=%h exp=fffffffe", m); end
        checks++;
        if (c !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", c); end
        va[0] = 1; vb[0] = 1;
        idx = 0;
        offer(1, 200, idx);
        wait_out(1'b1, m, c, to, v);
        checks++;
        if (to || m !== 32'd1) begin failures++; $display("FAIL next_sum got=%h exp=1", m); end
        checks++;
        if (c !== 16'd1) begin failures++; $display("FAIL next_count got=%0d exp=1", c); end
    endtask

    task automatic test_wrap;
        int idx; logic [31:0] m; logic [15:0] c; bit to, v;
        va[0] = 32'h8000_0000; vb[0] = 1; va[1] = 32'h8000_0000; vb[1] = 1;
        idx = 0;
        offer(2, 200, idx);
        wait_out(1'b1, m, c, to, v);
        checks++;
        if (to || m !== 32'd0) begin failures++; $display("FAIL wrap_sum got=%h exp=0", m); end
        checks++;
        if (c !== 16'd2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", c); end
    endtask

    task automatic test_credit;
        int idx; logic [31:0] m; logic [15:0] c; bit to, v;
        va[0] = 1; vb[0] = 2; va[1] = 3; vb[1] = 4;
        va[2] = 5; vb[2] = 6; va[3] = 7; vb[3] = 8;
        req_rdy_en = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        in_val = 1'b1;
        in_msg = {va[0], vb[0]};
        @(negedge clk);
        checks++;
        if ({in_rdy, mul_req_val} !== 2'b01) begin failures++; $display("FAIL req_rdy_gate got=%b exp=01", {in_rdy, mul_req_val}); end
        @(posedge clk);
        #1;
        hold_resp  = 1'b1;
        req_rdy_en = 1'b1;
        idx = 0;
        offer(4, 10, idx);
        checks++;
        if (idx != 2) begin failures++; $display("FAIL credit_fires got=%0d exp=2", idx); end
        in_val = 1'b1;
        in_msg = {va[2], vb[2]};
        @(negedge clk);
        checks++;
        if ({in_rdy, mul_req_val} !== 2'b00) begin failures++; $display("FAIL credit_stall got=%b exp=00", {in_rdy, mul_req_val}); end
        @(posedge clk);
        #1;
        hold_resp = 1'b0;
        offer(4, 200, idx);
        wait_out(1'b1, m, c, to, v);
        checks++;
        if (to || idx != 4 || m !== ref_sum(4)) begin failures++; $display("FAIL credit_sum got=%0d exp=%0d", m, ref_sum(4)); end
        checks++;
        if (c !== 16'd4) begin failures++; $display("FAIL credit_count got=%0d exp=4", c); end
    endtask

    task automatic test_backpressure;
        int idx; logic [31:0] m; logic [15:0] c; bit to, v;
        va[0] = 3; vb[0] = 7; va[1] = 5; vb[1] = 5;
        idx = 0;
        offer(2, 200, idx);
        wait_out(1'b0, m, c, to, v);
        checks++;
        if (to || m !== 32'd46) begin failures++; $display("FAIL bp_first got=%0d exp=46", m); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({out_val, in_rdy, out_msg, out_count} !== {1'b1, 1'b0, 32'd46, 16'd2}) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got=%b/%b/%0d/%0d exp=1/0/46/2", k, out_val, in_rdy, out_msg, out_count);
            end
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_val !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", out_val); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_drain;
        int idx, g; logic [31:0] m, e; logic [15:0] c; bit to, v;
        hold_resp = 1'b1;
        va[0] = 6; vb[0] = 7;
        idx = 0;
        offer(1, 200, idx);
        @(negedge clk);
        checks++;
        if ({in_rdy, mul_resp_rdy, out_val} !== 3'b010) begin failures++; $display("FAIL drain_state got=%b exp=010", {in_rdy, mul_resp_rdy, out_val}); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_rdy, mul_req_val, mul_resp_rdy, out_val} !== 4'b0000) begin
            failures++;
            $display("FAIL drain_reset got=%b exp=0000", {in_rdy, mul_req_val, mul_resp_rdy, out_val});
        end
        @(posedge clk);
        #1;
        reset     = 1'b1;
        hold_resp = 1'b0;
        g = 0;
        while (pq.size() != 0 && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        checks++;
        if (g >= 50) begin failures++; $display("FAIL late_resp_timeout got=%0d exp=<50", g); end
`ifdef IMUL_DOT_ERR_CHECK_EN
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL late_err got=%b exp=1", err); end
        e = 32'd0;
`else
        e = 32'd42;
`endif
        hold_resp = 1'b1;
        va[0] = 2; vb[0] = 3; va[1] = 3; vb[1] = 3; va[2] = 2; vb[2] = 2;
        idx = 0;
        offer(3, 8, idx);
        checks++;
        if (idx != 2) begin failures++; $display("FAIL post_reset_credit got=%0d exp=2", idx); end
        hold_resp = 1'b0;
        offer(3, 200, idx);
        wait_out(1'b1, m, c, to, v);
        e = e + ref_sum(3);
        checks++;
        if (to || m !== e) begin failures++; $display("FAIL post_reset_sum got=%0d exp=%0d", m, e); end
        checks++;
        if (c !== 16'd3) begin failures++; $display("FAIL post_reset_count got=%0d exp=3", c); end
    endtask

    task automatic test_random;
        int idx, n; logic [31:0] m; logic [15:0] c; bit to, v;
        rand_rdy = 1'b1;
        lat_min  = 1;
        lat_max  = 5;
        for (int s = 0; s < 8; s++) begin
            n = int'($urandom_range(6, 1));
            for (int i = 0; i < n; i++) begin
                va[i] = $urandom;
                vb[i] = (s < 2) ? $urandom_range(255, 0) : $urandom;
            end
            idx = 0;
            offer(n, 400, idx);
            wait_out(1'b1, m, c, to, v);
            checks++;
            if (to || idx != n || m !== ref_sum(n)) begin
                failures++;
                $display("FAIL rand_sum stream=%0d got=%h exp=%h", s, m, ref_sum(n));
            end
            checks++;
            if (c !== 16'(n)) begin failures++; $display("FAIL rand_count stream=%0d got=%0d exp=%0d", s, c, n); end
        end
        rand_rdy = 1'b0;
        lat_min  = 3;
        lat_max  = 3;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_then_next();
        test_wrap();
        test_credit();
        test_backpressure();
        test_reset_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
